// File: rtl/tpu_drain_pkg.sv
// tpu_drain_pkg: shared state encoding and row-counter width for the result drainer
package tpu_drain_pkg;
  localparam int ROW_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} drain_state_t;
endpackage

// File: rtl/tpu_result_drainer_if.sv
// tpu_result_drainer_if: aligned-row valid/ready stream from the drainer to the result buffer
interface tpu_result_drainer_if #(parameter int W = 2048) ();
  logic valid;
  logic ready;
  logic last;
  logic [W-1:0] data;
  modport master(output valid, output data, output last, input ready);
  modport slave(input valid, input data, input last, output ready);
endinterface

// File: rtl/tpu_row_fifo.sv
// tpu_row_fifo: first-word-fall-through synchronous FIFO holding one aligned row plus its last tag per entry
module tpu_row_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = empty ? '0 : mem[rd];
  // storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
  // pointers and occupancy; clr discards every entry
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/tpu_result_drainer.sv
// tpu_result_drainer: deskews systolic-array output rows, buffers them and streams whole rows out; ReLU at FIFO write with TPU_DRAIN_RELU_EN
module tpu_result_drainer
  import tpu_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = 64,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic start,
  input  logic [ROW_CNT_W-1:0] num_rows,
  input  logic relu_en,
  input  logic col_valid,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] results_in,
  tpu_result_drainer_if.master out,
  output logic busy,
  output logic done,
  output logic overflow_err,
  output logic [31:0] rows_count
);
  localparam int RW = DATA_WIDTH*ARRAY_SIZE;
`ifdef TPU_DRAIN_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif
  drain_state_t state;
  logic [ROW_CNT_W-1:0] n_rows, rows_acc, rows_in;
  logic [ARRAY_SIZE-2:0] vsr;
  logic [RW-1:0] wr_row;
  logic [RW:0] fifo_out;
  logic abort, start_ok, accept, aligned_vld, pop, push, drop, full, empty, relu_act, last_tag;
  assign abort = !enable;
  assign start_ok = enable && start && state == IDLE;
  assign accept = col_valid && state == COLLECT && rows_acc < n_rows;
  assign aligned_vld = vsr[ARRAY_SIZE-2];
  assign pop = out.valid && out.ready;
  assign push = aligned_vld && (!full || pop);
  assign drop = aligned_vld && full && !pop;
  assign relu_act = RELU_ON && relu_en;
  assign last_tag = rows_in == n_rows - 1'b1;
  assign out.valid = !empty;
  assign {out.last, out.data} = fifo_out;
  // row-start marker travels with the slowest (column 0) data
  always_ff @(posedge clk) begin
    if (!rst_n || abort) vsr <= '0;
    else vsr <= (vsr << 1) | (ARRAY_SIZE-1)'(accept);
  end
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
    localparam int D = ARRAY_SIZE-1-j;
    logic [DATA_WIDTH-1:0] col, col_d;
    assign col = results_in[j*DATA_WIDTH +: DATA_WIDTH];
    if (D == 0) begin : g_thru
      assign col_d = col;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dl [D];
      // hold earlier columns until the last column of the row appears
      always_ff @(posedge clk) begin
        dl[0] <= col;
        for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
      end
      assign col_d = dl[D-1];
    end
    assign wr_row[j*DATA_WIDTH +: DATA_WIDTH] = (relu_act && col_d[DATA_WIDTH-1]) ? '0 : col_d;
  end
  tpu_row_fifo #(.W(RW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(abort),
    .push(push),
    .din({last_tag, wr_row}),
    .pop(pop),
    .dout(fifo_out),
    .full(full),
    .empty(empty)
  );
  // job counters; rows_in counts every aligned row whether kept or dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_rows <= '0;
      rows_acc <= '0;
      rows_in <= '0;
      rows_count <= '0;
      overflow_err <= 1'b0;
    end else begin
      rows_count <= rows_count + 32'(pop);
      overflow_err <= start_ok ? 1'b0 : overflow_err | drop;
      n_rows <= start_ok ? num_rows : n_rows;
      rows_acc <= (abort || start_ok) ? '0 : rows_acc + ROW_CNT_W'(accept);
      rows_in <= (abort || start_ok) ? '0 : rows_in + ROW_CNT_W'(aligned_vld);
    end
  end
  // job sequencing with registered busy/done
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= num_rows == '0 ? DONE : COLLECT;
          busy <= 1'b1;
          done <= num_rows == '0;
        end
        COLLECT: if (rows_in == n_rows) state <= FLUSH;
        FLUSH: if (empty) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
